ceyloniac_pc_controller: RTL and testbench

Next-PC sequencer for the Ceyloniac fetch stage. Holds the architectural PC register, arbitrates the four next-PC sources (sequential, branch, jump, exception), and drives the 2-bit select of the PC select mux. Handles stalls, buffers redirects that arrive while stalled, and issues a timed pipeline flush on every redirect.

---
 rtl/ceyloniac_pkg.sv | 21 ++
 rtl/ceyloniac_pc_sel_mux.sv | 25 ++
 rtl/ceyloniac_pc_controller.sv | 206 ++++++++++++++++++++
 tb/tb_ceyloniac_pc_controller.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ceyloniac_pkg.sv
// Shared encodings for the Ceyloniac fetch-stage PC sequencer.
package ceyloniac_pkg;

  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned FLUSH_CNT_W = 3;

  typedef enum logic [1:0] {
    PC_SRC_SEQ = 2'b00,
    PC_SRC_BR  = 2'b01,
    PC_SRC_JMP = 2'b10,
    PC_SRC_EXC = 2'b11
  } pc_src_e;

  typedef enum logic [1:0] {
    INIT = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10,
    PEND = 2'b11
  } state_e;

endpackage

// File: rtl/ceyloniac_pc_sel_mux.sv
// Four-way PC select mux: pc+4, branch, jump, exception vector.
module ceyloniac_pc_sel_mux
  import ceyloniac_pkg::*;
#(
  parameter int unsigned ALU_DATA_WIDTH = 32
) (
  input  logic [1:0]                sel,
  input  logic [ALU_DATA_WIDTH-1:0] seq_pc,
  input  logic [ALU_DATA_WIDTH-1:0] br_pc,
  input  logic [ALU_DATA_WIDTH-1:0] jmp_pc,
  input  logic [ALU_DATA_WIDTH-1:0] exc_pc,
  output logic [ALU_DATA_WIDTH-1:0] next_pc
);

  always_comb begin
    next_pc = seq_pc;
    case (sel)
      PC_SRC_BR:  next_pc = br_pc;
      PC_SRC_JMP: next_pc = jmp_pc;
      PC_SRC_EXC: next_pc = exc_pc;
      default:    next_pc = seq_pc;
    endcase
  end

endmodule

// File: rtl/ceyloniac_pc_controller.sv
// Next-PC sequencer: PC register, redirect arbitration, stall buffering, flush pulse.
// Optional trap path (exception input, epc) enabled by CEYLONIAC_PC_EXC_EN.
module ceyloniac_pc_controller
  import ceyloniac_pkg::*;
#(
  parameter int unsigned                 ALU_DATA_WIDTH = 32,
  parameter logic [ALU_DATA_WIDTH-1:0]   RESET_PC       = ALU_DATA_WIDTH'(32'h0000_0000),
  parameter logic [ALU_DATA_WIDTH-1:0]   EXC_VECTOR     = ALU_DATA_WIDTH'(32'h0000_0080),
  parameter int unsigned                 FLUSH_CYCLES   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      branch_taken,
  input  logic [ALU_DATA_WIDTH-1:0] branch_target,
  input  logic                      jump,
  input  logic [ALU_DATA_WIDTH-1:0] jump_target,
`ifdef CEYLONIAC_PC_EXC_EN
  input  logic                      exception,
  output logic [ALU_DATA_WIDTH-1:0] epc,
`endif
  output logic [ALU_DATA_WIDTH-1:0] pc,
  output logic [1:0]                pc_src,
  output logic                      pc_valid,
  output logic                      flush
);

  localparam int unsigned W = ALU_DATA_WIDTH;
  localparam logic [W-1:0] ALIGN_MASK = ~W'(INSTR_BYTES - 1);

  state_e                 state_q, state_d;
  pc_src_e                pend_src_q, pend_src_d;
  logic [W-1:0]           pend_tgt_q, pend_tgt_d;
  logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]           pc_d;
  logic                   pc_valid_d, flush_d, redirect;
  pc_src_e                sel, req_src, eff_src;
  logic [W-1:0]           req_tgt, eff_tgt;
  logic [W-1:0]           seq_pc, br_in, jmp_in, mux_pc;
  logic                   exc_req;

`ifdef CEYLONIAC_PC_EXC_EN
  logic [W-1:0] epc_d;
  assign exc_req = exception & (state_q != INIT);
`else
  assign exc_req = 1'b0;
`endif

  assign seq_pc = pc + W'(INSTR_BYTES);
  assign pc_src = sel;

  // Highest-priority live request (jump > branch), target word-aligned
  always_comb begin
    req_src = PC_SRC_SEQ;
    req_tgt = '0;
    if (jump) begin
      req_src = PC_SRC_JMP;
      req_tgt = jump_target & ALIGN_MASK;
    end else if (branch_taken) begin
      req_src = PC_SRC_BR;
      req_tgt = branch_target & ALIGN_MASK;
    end
  end

  // Pending redirect merged with live requests; only strictly higher priority overwrites
  always_comb begin
    eff_src = pend_src_q;
    eff_tgt = pend_tgt_q;
    if (req_src > pend_src_q) begin
      eff_src = req_src;
      eff_tgt = req_tgt;
    end
  end

  assign br_in  = (state_q == PEND) ? eff_tgt : (branch_target & ALIGN_MASK);
  assign jmp_in = (state_q == PEND) ? eff_tgt : (jump_target & ALIGN_MASK);

  ceyloniac_pc_sel_mux #(
    .ALU_DATA_WIDTH(W)
  ) u_mux (
    .sel     (sel),
    .seq_pc  (seq_pc),
    .br_pc   (br_in),
    .jmp_pc  (jmp_in),
    .exc_pc  (EXC_VECTOR),
    .next_pc (mux_pc)
  );

  // Next-state, select and register-next logic
  always_comb begin
    state_d    = state_q;
    sel        = PC_SRC_SEQ;
    pc_d       = pc;
    pc_valid_d = pc_valid;
    pend_src_d = pend_src_q;
    pend_tgt_d = pend_tgt_q;
    redirect   = 1'b0;
`ifdef CEYLONIAC_PC_EXC_EN
    epc_d      = epc;
`endif
    case (state_q)
      INIT: begin
        state_d    = RUN;
        pc_valid_d = 1'b1;
      end
      RUN: begin
        if (stall) begin
          pc_valid_d = 1'b0;
          if (req_src != PC_SRC_SEQ) begin
            pend_src_d = req_src;
            pend_tgt_d = req_tgt;
            state_d    = PEND;
          end else begin
            state_d = HOLD;
          end
        end else begin
          sel        = req_src;
          pc_d       = mux_pc;
          redirect   = (req_src != PC_SRC_SEQ);
          pc_valid_d = 1'b1;
        end
      end
      HOLD: begin
        pc_valid_d = 1'b0;
        if (req_src != PC_SRC_SEQ) begin
          pend_src_d = req_src;
          pend_tgt_d = req_tgt;
          state_d    = PEND;
        end else if (!stall) begin
          state_d    = RUN;
          pc_valid_d = 1'b1;
        end
      end
      PEND: begin
        if (stall) begin
          pc_valid_d = 1'b0;
          pend_src_d = eff_src;
          pend_tgt_d = eff_tgt;
        end else begin
          sel        = eff_src;
          pc_d       = mux_pc;
          redirect   = 1'b1;
          pend_src_d = PC_SRC_SEQ;
          pend_tgt_d = '0;
          state_d    = RUN;
          pc_valid_d = 1'b1;
        end
      end
      default: state_d = INIT;
    endcase

    // Trap overrides stall and discards any buffered redirect
    if (exc_req) begin
      sel        = PC_SRC_EXC;
      pc_d       = mux_pc;
      redirect   = 1'b1;
      pend_src_d = PC_SRC_SEQ;
      pend_tgt_d = '0;
      state_d    = RUN;
      pc_valid_d = 1'b1;
`ifdef CEYLONIAC_PC_EXC_EN
      epc_d      = pc;
`endif
    end
  end

  // Flush pulse: a redirect (re)loads the down-counter
  always_comb begin
    cnt_d   = cnt_q;
    flush_d = 1'b0;
    if (redirect) begin
      cnt_d   = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
      flush_d = 1'b1;
    end else if (cnt_q != '0) begin
      cnt_d   = cnt_q - FLUSH_CNT_W'(1);
      flush_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= INIT;
      pc         <= RESET_PC;
      pc_valid   <= 1'b0;
      flush      <= 1'b0;
      cnt_q      <= '0;
      pend_src_q <= PC_SRC_SEQ;
      pend_tgt_q <= '0;
`ifdef CEYLONIAC_PC_EXC_EN
      epc        <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pc         <= pc_d;
      pc_valid   <= pc_valid_d;
      flush      <= flush_d;
      cnt_q      <= cnt_d;
      pend_src_q <= pend_src_d;
      pend_tgt_q <= pend_tgt_d;
`ifdef CEYLONIAC_PC_EXC_EN
      epc        <= epc_d;
`endif
    end
  end

endmodule

// File: tb/tb_ceyloniac_pc_controller.sv
// Directed scoreboard bench for ceyloniac_pc_controller (trap steps need CEYLONIAC_PC_EXC_EN).
module tb_ceyloniac_pc_controller;

  typedef struct packed {
    logic [31:0] pc;
    logic        valid;
    logic        flush;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken, jump;
  logic [31:0] branch_target, jump_target;
  logic [31:0] pc;
  logic [1:0]  pc_src;
  logic        pc_valid, flush;
`ifdef CEYLONIAC_PC_EXC_EN
  logic        exception;
  logic [31:0] epc;
`endif

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  ceyloniac_pc_controller #(
    .ALU_DATA_WIDTH(32),
    .RESET_PC      (32'h0000_0000),
    .EXC_VECTOR    (32'h0000_0080),
    .FLUSH_CYCLES  (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
`ifdef CEYLONIAC_PC_EXC_EN
    .exception     (exception),
    .epc           (epc),
`endif
    .pc            (pc),
    .pc_src        (pc_src),
    .pc_valid      (pc_valid),
    .flush         (flush)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Combinational select check, after inputs settle
  task automatic chk_src(input logic [1:0] want);
    #1;
    chk("pc_src", 32'(pc_src), 32'(want));
  endtask

  // Push expected post-edge outputs, clock once, pop and compare
  task automatic cyc(input logic [31:0] p, input logic v, input logic f);
    exp_t e;
    q.push_back('{pc: p, valid: v, flush: f});
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("pc", pc, e.pc);
    chk("pc_valid", 32'(pc_valid), 32'(e.valid));
    chk("flush", 32'(flush), 32'(e.flush));
  endtask

  task automatic drive(input logic s, input logic b, input logic [31:0] bt,
                       input logic j, input logic [31:0] jt);
    stall = s; branch_taken = b; branch_target = bt; jump = j; jump_target = jt;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
`ifdef CEYLONIAC_PC_EXC_EN
    exception = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", 32'(pc_valid), 32'h0);
    chk("rst_flush", 32'(flush), 32'h0);
    chk("rst_src", 32'(pc_src), 32'h0);
    reset = 1'b0;

    // Free-running sequential fetch
    cyc(32'h0, 1, 0);
    cyc(32'h4, 1, 0);
    cyc(32'h8, 1, 0);

    // Taken branch at pc=8
    drive(0, 1, 32'h100, 0, 0);
    chk_src(2'b01);
    cyc(32'h100, 1, 1);
    drive(0, 0, 0, 0, 0);
    cyc(32'h104, 1, 1);
    cyc(32'h108, 1, 0);

    // Jump beats branch; low target bits dropped
    drive(0, 1, 32'h100, 1, 32'h201);
    chk_src(2'b10);
    cyc(32'h200, 1, 1);
    drive(0, 0, 0, 0, 0);
    cyc(32'h204, 1, 1);
    cyc(32'h208, 1, 0);

    // Stall -> HOLD, branch buffered -> PEND, release applies it
    drive(1, 0, 0, 0, 0);
    cyc(32'h208, 0, 0);
    drive(1, 1, 32'h40, 0, 0);
    chk_src(2'b00);
    cyc(32'h208, 0, 0);
    drive(1, 0, 0, 0, 0);
    cyc(32'h208, 0, 0);
    cyc(32'h208, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk_src(2'b01);
    cyc(32'h40, 1, 1);
    cyc(32'h44, 1, 1);
    cyc(32'h48, 1, 0);

    // Back-to-back redirects reload the flush counter
    drive(0, 1, 32'h100, 0, 0);
    cyc(32'h100, 1, 1);
    drive(0, 1, 32'h200, 0, 0);
    cyc(32'h200, 1, 1);
    drive(0, 0, 0, 0, 0);
    cyc(32'h204, 1, 1);
    cyc(32'h208, 1, 0);

    // Pending jump ignores a later branch
    drive(1, 0, 0, 0, 0);
    cyc(32'h208, 0, 0);
    drive(1, 0, 0, 1, 32'h60);
    cyc(32'h208, 0, 0);
    drive(1, 1, 32'h500, 0, 0);
    cyc(32'h208, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk_src(2'b10);
    cyc(32'h60, 1, 1);
    cyc(32'h64, 1, 1);
    cyc(32'h68, 1, 0);

    // Pending branch overwritten by a later jump
    drive(1, 0, 0, 0, 0);
    cyc(32'h68, 0, 0);
    drive(1, 1, 32'h70, 0, 0);
    cyc(32'h68, 0, 0);
    drive(1, 0, 0, 1, 32'h90);
    cyc(32'h68, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk_src(2'b10);
    cyc(32'h90, 1, 1);
    cyc(32'h94, 1, 1);
    cyc(32'h98, 1, 0);

    // HOLD released without request: pc re-presented, then advances
    drive(1, 0, 0, 0, 0);
    cyc(32'h98, 0, 0);
    drive(0, 0, 0, 0, 0);
    cyc(32'h98, 1, 0);
    cyc(32'h9C, 1, 0);

`ifdef CEYLONIAC_PC_EXC_EN
    // Trap during stall with a buffered branch
    drive(0, 0, 0, 1, 32'h20);
    cyc(32'h20, 1, 1);
    drive(1, 0, 0, 0, 0);
    cyc(32'h20, 0, 1);
    drive(1, 1, 32'h40, 0, 0);
    cyc(32'h20, 0, 0);
    drive(1, 0, 0, 0, 0);
    exception = 1'b1;
    chk_src(2'b11);
    cyc(32'h80, 1, 1);
    chk("epc", epc, 32'h20);
    exception = 1'b0;
    drive(0, 0, 0, 0, 0);
    cyc(32'h84, 1, 1);
    cyc(32'h88, 1, 0);
`endif

    // Sequential wrap at the top of the address space
    drive(0, 0, 0, 1, 32'hFFFF_FFFC);
    cyc(32'hFFFF_FFFC, 1, 1);
    drive(0, 0, 0, 0, 0);
    cyc(32'h0, 1, 1);
    cyc(32'h4, 1, 0);

    // Reset in the middle of a flush pulse
    drive(0, 0, 0, 1, 32'h300);
    cyc(32'h300, 1, 1);
    drive(0, 0, 0, 0, 0);
    reset = 1'b1;
    cyc(32'h0, 0, 0);
    reset = 1'b0;
    cyc(32'h0, 1, 0);
    cyc(32'h4, 1, 0);

    // Reset while a redirect is pending discards it
    drive(1, 0, 0, 0, 0);
    cyc(32'h4, 0, 0);
    drive(1, 1, 32'h40, 0, 0);
    cyc(32'h4, 0, 0);
    drive(0, 0, 0, 0, 0);
    reset = 1'b1;
    cyc(32'h0, 0, 0);
    reset = 1'b0;
    cyc(32'h0, 1, 0);
    cyc(32'h4, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
